fc8_gamepad_serial_reader: RTL and testbench

Host-side initiator for a NES-style serial gamepad (parallel-in/serial-out shift register inside the pad). It periodically drives pad_latch and pad_clk, shifts in 8 button bits plus one presence bit on pad_data, and presents an active-high parallel state word. Its outputs feed the raw-input side of the debouncing input controller, so state_out[5:0] maps one-to-one onto the raw up/down/left/right/A/B lines.

---
 rtl/fc8_input_pkg.sv | 52 +++++
 rtl/fc8_gamepad_serial_reader.sv | 147 ++++++++++++++
 tb/tb_fc8_gamepad_serial_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fc8_input_pkg.sv
// Shared definitions for the FC8 gamepad input path: FSM states, button
// positions in the parallel state word, and the pad's serial bit order.
package fc8_input_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_GAP   = 3'd2,
        ST_CLKH  = 3'd3,
        ST_CLKL  = 3'd4,
        ST_DONE  = 3'd5
    } pad_state_e;

    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_A      = 4;
    localparam int unsigned BTN_B      = 5;
    localparam int unsigned BTN_START  = 6;
    localparam int unsigned BTN_SELECT = 7;

    localparam int unsigned SER_A       = 0;
    localparam int unsigned SER_B       = 1;
    localparam int unsigned SER_SELECT  = 2;
    localparam int unsigned SER_START   = 3;
    localparam int unsigned SER_UP      = 4;
    localparam int unsigned SER_DOWN    = 5;
    localparam int unsigned SER_LEFT    = 6;
    localparam int unsigned SER_RIGHT   = 7;
    localparam int unsigned SER_PRESENT = 8;

    localparam int unsigned NUM_SAMPLES = 9;

    // Active-low serial samples to active-high state word; all zero if no pad.
    function automatic logic [7:0] map_buttons(input logic [NUM_SAMPLES-1:0] samples);
        logic [7:0] word;
        word = 8'h00;
        if (samples[SER_PRESENT]) begin
            word[BTN_UP]     = ~samples[SER_UP];
            word[BTN_DOWN]   = ~samples[SER_DOWN];
            word[BTN_LEFT]   = ~samples[SER_LEFT];
            word[BTN_RIGHT]  = ~samples[SER_RIGHT];
            word[BTN_A]      = ~samples[SER_A];
            word[BTN_B]      = ~samples[SER_B];
            word[BTN_START]  = ~samples[SER_START];
            word[BTN_SELECT] = ~samples[SER_SELECT];
        end
        return word;
    endfunction

endpackage

// File: rtl/fc8_gamepad_serial_reader.sv
// Periodic host-side reader for a NES-style serial gamepad: latches the pad,
// clocks out 8 button bits plus a presence bit, and publishes a state word.
module fc8_gamepad_serial_reader
    import fc8_input_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 30,
    parameter int unsigned LATCH_CYCLES = 60,
    parameter int unsigned POLL_PERIOD  = 83333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       poll_en,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data,
    output logic [7:0] state_out,
    output logic       state_valid,
    output logic       connected_out
);

    localparam int unsigned CNT_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TIMER_W = $clog2(POLL_PERIOD);
    localparam int unsigned IDX_W   = 4;

    pad_state_e         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   bit_idx, bit_idx_d;
    logic [7:0]         shreg, shreg_d;
    logic [TIMER_W-1:0] timer;
    logic               timer_wrap_c;
    logic               start_c;
    logic               done_c;

    assign timer_wrap_c = (timer == TIMER_W'(POLL_PERIOD - 1));
    assign start_c      = timer_wrap_c && poll_en && (state == ST_IDLE);

    // Free-running poll timer, independent of the transaction FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_wrap_c) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    // Next-state logic; bit_idx counts samples already taken.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        done_c    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_c) begin
                    state_d   = ST_LATCH;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            ST_LATCH: begin
                if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    shreg_d   = {pad_data, shreg[7:1]};
                    bit_idx_d = IDX_W'(1);
                    state_d   = ST_CLKH;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_CLKH: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    state_d = ST_CLKL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_CLKL: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_idx == IDX_W'(SER_PRESENT)) begin
                        state_d = ST_DONE;
                        done_c  = 1'b1;
                    end else begin
                        shreg_d   = {pad_data, shreg[7:1]};
                        bit_idx_d = bit_idx + IDX_W'(1);
                        state_d   = ST_CLKH;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered pad strobes and results; the presence bit is taken live on the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_latch     <= 1'b0;
            pad_clk       <= 1'b0;
            state_valid   <= 1'b0;
            state_out     <= 8'h00;
            connected_out <= 1'b0;
        end else begin
            pad_latch   <= (state_d == ST_LATCH);
            pad_clk     <= (state_d == ST_CLKH);
            state_valid <= done_c;
            if (done_c) begin
                state_out     <= map_buttons({pad_data, shreg});
                connected_out <= pad_data;
            end
        end
    end

endmodule

// File: tb/tb_fc8_gamepad_serial_reader.sv
// Bench for fc8_gamepad_serial_reader with a behavioural pad and a
// cycle-level expectation model of the poll transaction.
module tb_fc8_gamepad_serial_reader;

    localparam int CD = 2;
    localparam int LC = 3;
    localparam int PP = 64;
    localparam int TXN_LEN = LC + 17 * CD + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       poll_en;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic [7:0] state_out;
    logic       state_valid;
    logic       connected_out;

    int vectors = 0;
    int miscompares = 0;

    fc8_gamepad_serial_reader #(
        .CLK_DIV(CD), .LATCH_CYCLES(LC), .POLL_PERIOD(PP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .poll_en(poll_en),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data),
        .state_out(state_out), .state_valid(state_valid), .connected_out(connected_out)
    );

    always #5 clk = ~clk;

    // Pad: parallel load while latched, shift on pad_clk rise, 1s after bit 7.
    logic [7:0]  pad_bits;
    logic        plugged;
    logic [15:0] pad_sr = 16'hFFFF;
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_sr <= {8'hFF, pad_bits};
        else           pad_sr <= {1'b1, pad_sr[15:1]};
    end
    assign pad_data = plugged ? pad_sr[0] : 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial order A,B,Select,Start,Up,Down,Left,Right -> word positions.
    function automatic logic [7:0] model_word(input logic [7:0] ser, input bit plug);
        int pos [8] = '{4, 5, 7, 6, 0, 1, 2, 3};
        logic [7:0] w = 8'h00;
        if (plug)
            for (int i = 0; i < 8; i++) w[pos[i]] = ~ser[i];
        return w;
    endfunction

    // Posedges since reset release; the DUT poll timer must equal k mod PP.
    int k = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    bit         active = 0;
    int         s_cyc, r, q, lat_cnt, rise_cnt;
    logic [7:0] cap_bits;
    bit         cap_plug;
    logic [7:0] exp_state = 8'h00;
    bit         exp_conn = 0;
    bit         e_latch, e_clk, e_valid;
    logic       prev_clk = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0; exp_state = 8'h00; exp_conn = 0;
            check("rst pad_latch", 32'(pad_latch), 0);
            check("rst pad_clk", 32'(pad_clk), 0);
            check("rst state_valid", 32'(state_valid), 0);
            check("rst state_out", 32'(state_out), 0);
            check("rst connected", 32'(connected_out), 0);
        end else begin
            if (!active && (k % PP) == PP - 1 && poll_en) begin
                active = 1; s_cyc = k; lat_cnt = 0; rise_cnt = 0;
            end
            r = active ? k - s_cyc : 0;
            e_latch = active && r >= 1 && r <= LC;
            e_clk = 0;
            if (active && r >= LC + CD + 1) begin
                q = r - (LC + CD + 1);
                e_clk = (q < 16 * CD) && ((q % (2 * CD)) < CD);
            end
            e_valid = active && r == TXN_LEN;
            if (active && r == 1) begin cap_bits = pad_bits; cap_plug = plugged; end
            if (active && pad_latch) lat_cnt++;
            if (active && pad_clk && !prev_clk) rise_cnt++;
            if (e_valid) begin
                exp_state = model_word(cap_bits, cap_plug);
                exp_conn  = cap_plug;
                check("latch high cycles", 32'(lat_cnt), 3);
                check("pad_clk rises", 32'(rise_cnt), 8);
                active = 0;
            end
            check("pad_latch", 32'(pad_latch), 32'(e_latch));
            check("pad_clk", 32'(pad_clk), 32'(e_clk));
            check("state_valid", 32'(state_valid), 32'(e_valid));
            check("state_out", 32'(state_out), 32'(exp_state));
            check("connected_out", 32'(connected_out), 32'(exp_conn));
        end
        prev_clk = pad_clk;
    end

    task automatic wait_valid(output int at_k);
        at_k = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (state_valid) begin
                at_k = k;
                return;
            end
        end
        check("state_valid timeout", 0, 1);
    endtask

    int vk;
    int latch_seen;

    initial begin
        rst_n = 1'b0; poll_en = 1'b1; plugged = 1'b1; pad_bits = 8'hFF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: async reset in the middle of LATCH
        for (int i = 0; i < 200 && !pad_latch; i++) @(negedge clk);
        check("latch reached", 32'(pad_latch), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("async pad_latch", 32'(pad_latch), 0);
        check("async pad_clk", 32'(pad_clk), 0);
        check("async state_out", 32'(state_out), 0);
        check("async connected", 32'(connected_out), 0);
        pad_bits = 8'h7E;
        @(posedge clk); #1 rst_n = 1'b1;

        // 2: A and Right pressed; first poll after reset at cycle 101
        wait_valid(vk);
        check("t2 valid cycle", 32'(vk), 101);
        check("t2 state_out", 32'(state_out), 32'h18);
        check("t2 connected", 32'(connected_out), 1);

        // 3: unplugged pad
        plugged = 1'b0;
        wait_valid(vk);
        check("t3 state_out", 32'(state_out), 32'h00);
        check("t3 connected", 32'(connected_out), 0);

        // 4: all pressed, then all released
        plugged = 1'b1; pad_bits = 8'h00;
        wait_valid(vk);
        check("t4 all pressed", 32'(state_out), 32'hFF);
        check("t4 connected", 32'(connected_out), 1);
        pad_bits = 8'hFF;
        wait_valid(vk);
        check("t4 all released", 32'(state_out), 32'h00);

        // 5: polling disabled, then dropped mid-transaction
        poll_en = 1'b0; latch_seen = 0; pad_bits = 8'hFE;
        repeat (3 * PP) begin @(negedge clk); if (pad_latch) latch_seen++; end
        check("t5 no latch", 32'(latch_seen), 0);
        check("t5 held state", 32'(state_out), 32'h00);
        poll_en = 1'b1;
        for (int i = 0; i < 200 && !pad_clk; i++) @(negedge clk);
        check("t5 clkh reached", 32'(pad_clk), 1);
        @(posedge clk); #1 poll_en = 1'b0;
        wait_valid(vk);
        check("t5 completes", 32'(state_out), 32'h10);
        latch_seen = 0;
        repeat (2 * PP) begin @(negedge clk); if (pad_latch) latch_seen++; end
        check("t5 no further latch", 32'(latch_seen), 0);

        // 6: Select only, then Start only
        poll_en = 1'b1; pad_bits = 8'hFB;
        wait_valid(vk);
        check("t6 select", 32'(state_out), 32'h80);
        pad_bits = 8'hF7;
        wait_valid(vk);
        check("t6 start", 32'(state_out), 32'h40);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
